// File: rtl/clkrst_gen_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : clkrst_gen_if
// Description : Divisor programming bus for clkrst_gen.
//               div_wr  - write strobe for div_val (master -> slave)
//               div_val - new divisor, N-1 (master -> slave)
//               div_cur - divisor currently in effect (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface clkrst_gen_if #(
    parameter int DIVW = 8
) ();
    logic            div_wr;
    logic [DIVW-1:0] div_val;
    logic [DIVW-1:0] div_cur;

    modport master (
        output div_wr,
        output div_val,
        input  div_cur
    );

    modport slave (
        input  div_wr,
        input  div_val,
        output div_cur
    );
endinterface
`default_nettype wire

// File: rtl/clkrst_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : clkrst_gen
// Description : Programmable clock-enable / square-wave divider, debounced
//               reset button and stretched system reset for FPGA board tops.
//               Divide ratio N = div_cur + 1. All outputs are registered.
// Ports       : clk            - oscillator clock, all logic on posedge
//               power_on_reset - synchronous active-high reset
//               btn_n          - raw asynchronous button, low = pressed
//               div_bus        - divisor bus (div_wr, div_val, div_cur)
//               clk_en         - one-cycle pulse every N clk cycles
//               clk_out        - square wave toggling on every clk_en
//               btn_pressed    - debounced button level, 1 = pressed
//               btn_event      - one-cycle pulse on debounced press
//               system_reset   - reset stretched to the divided clock
// Revision    : 1.0 - initial release
// ============================================================================
module clkrst_gen #(
    parameter int DIVW       = 8,
    parameter int DIV_INIT   = 1,
    parameter int DEBOUNCE   = 16,
    parameter int RESET_HOLD = 8
) (
    input  logic         clk,
    input  logic         power_on_reset,
    input  logic         btn_n,
    clkrst_gen_if.slave  div_bus,
    output logic         clk_en,
    output logic         clk_out,
    output logic         btn_pressed,
    output logic         btn_event,
    output logic         system_reset
);

    localparam logic [DIVW-1:0] c_DIV_INIT  = DIVW'(DIV_INIT);
    localparam int              c_DBW       = $clog2(DEBOUNCE);
    localparam logic [c_DBW-1:0] c_DB_LAST  = c_DBW'(DEBOUNCE - 1);
    localparam int              c_HW        = $clog2(RESET_HOLD + 1);
    localparam logic [c_HW-1:0] c_HOLD_INIT = c_HW'(RESET_HOLD);
    localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [DIVW-1:0] r_cnt;
    logic [DIVW-1:0] r_div_cur;
    logic [DIVW-1:0] r_div_pend;
    logic            r_pend_vld;
    logic            r_clk_en;
    logic            r_clk_out;
    logic            w_tick;

    // Terminal count. r_cnt never exceeds r_div_cur because the divisor only
    // changes on this same edge, when r_cnt restarts from zero.
    assign w_tick = (r_cnt == r_div_cur);

    always_ff @(posedge clk) begin
        if (power_on_reset) begin
            r_cnt      <= '0;
            r_div_cur  <= c_DIV_INIT;
            r_div_pend <= '0;
            r_pend_vld <= 1'b0;
            r_clk_en   <= 1'b0;
            r_clk_out  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt     <= '0;
                r_clk_en  <= 1'b1;
                r_clk_out <= ~r_clk_out;
                // Swap divisors only at a period boundary so no runt period
                // is ever produced.
                if (r_pend_vld) begin
                    r_div_cur  <= r_div_pend;
                    r_pend_vld <= 1'b0;
                end
            end else begin
                r_cnt    <= r_cnt + DIVW'(1);
                r_clk_en <= 1'b0;
            end
            // Placed last so a write on a boundary edge survives the clear
            // above and is applied at the following boundary.
            if (div_bus.div_wr) begin
                r_div_pend <= div_bus.div_val;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_pressed;
    logic             r_btn_event;
    logic [c_DBW-1:0] r_db_cnt;
    logic             w_btn_now;

    assign w_btn_now = ~r_sync2;

    always_ff @(posedge clk) begin
        if (power_on_reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_btn_pressed <= 1'b0;
            r_btn_event   <= 1'b0;
            r_db_cnt      <= '0;
        end else begin
            r_sync1     <= btn_n;
            r_sync2     <= r_sync1;
            r_btn_event <= 1'b0;
            // For a single bit, "changed while differing" means "now equal
            // to the accepted state", so one compare restarts the count.
            if (w_btn_now == r_btn_pressed) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_cnt      <= '0;
                r_btn_pressed <= w_btn_now;
                r_btn_event   <= w_btn_now;   // press edge only, never release
            end else begin
                r_db_cnt <= r_db_cnt + c_DBW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset stretcher
    // ------------------------------------------------------------------
    logic            r_sys_rst;
    logic [c_HW-1:0] r_hold;

    always_ff @(posedge clk) begin
        if (power_on_reset || r_btn_pressed) begin
            r_sys_rst <= 1'b1;
            r_hold    <= c_HOLD_INIT;
        end else if (w_tick && (r_hold != '0)) begin
            // Counting on w_tick makes the release edge coincide with the
            // rising edge of clk_en.
            r_hold <= r_hold - c_HOLD_ONE;
            if (r_hold == c_HOLD_ONE) begin
                r_sys_rst <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign div_bus.div_cur = r_div_cur;
    assign clk_en          = r_clk_en;
    assign clk_out         = r_clk_out;
    assign btn_pressed     = r_btn_pressed;
    assign btn_event       = r_btn_event;
    assign system_reset    = r_sys_rst;

endmodule
`default_nettype wire

// File: tb/tb_clkrst_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_clkrst_gen
// Description : Directed self-checking bench for clkrst_gen (DIVW=8,
//               DIV_INIT=1, DEBOUNCE=16, RESET_HOLD=8). Cycle n is the clock
//               period following the n-th rising edge after reset release;
//               inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkrst_gen;

    logic clk;
    logic power_on_reset;
    logic btn_n;
    logic clk_en;
    logic clk_out;
    logic btn_pressed;
    logic btn_event;
    logic system_reset;

    clkrst_gen_if #(.DIVW(8)) div_bus ();

    clkrst_gen #(
        .DIVW       (8),
        .DIV_INIT   (1),
        .DEBOUNCE   (16),
        .RESET_HOLD (8)
    ) u_dut (
        .clk            (clk),
        .power_on_reset (power_on_reset),
        .btn_n          (btn_n),
        .div_bus        (div_bus),
        .clk_en         (clk_en),
        .clk_out        (clk_out),
        .btn_pressed    (btn_pressed),
        .btn_event      (btn_event),
        .system_reset   (system_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int sr_low   = 0;
    int ev_cnt   = 0;
    int en_cnt   = 0;
    int pr_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic next();
        @(negedge clk);
        cyc++;
        if (system_reset == 1'b0) sr_low++;
        if (btn_event)            ev_cnt++;
        if (clk_en)               en_cnt++;
        if (btn_pressed)          pr_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) next();
    endtask

    task automatic do_reset();
        btn_n          = 1'b1;
        div_bus.div_wr = 1'b0;
        power_on_reset = 1'b1;
        repeat (2) @(negedge clk);
        power_on_reset = 1'b0;
        cyc            = 0;
    endtask

    task automatic wait_pressed(input logic lvl, input int limit, input string tag);
        int n = 0;
        while (btn_pressed !== lvl && n < limit) begin
            next();
            n++;
        end
        check(tag, 32'(btn_pressed), 32'(lvl));
    endtask

    task automatic wait_ticks(input int k, input int limit, input string tag);
        int n = 0;
        while (en_cnt < k && n < limit) begin
            next();
            n++;
        end
        check(tag, 32'(en_cnt), 32'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks2 [8] = '{2, 4, 6, 11, 16, 21, 26, 31};
        logic exp_en;
        logic exp_out;

        btn_n          = 1'b1;
        div_bus.div_wr = 1'b0;
        div_bus.div_val = 8'd0;
        power_on_reset = 1'b1;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst clk_en",       32'(clk_en),          0);
        check("rst clk_out",      32'(clk_out),         0);
        check("rst div_cur",      32'(div_bus.div_cur), 1);
        check("rst btn_pressed",  32'(btn_pressed),     0);
        check("rst btn_event",    32'(btn_event),       0);
        check("rst system_reset", 32'(system_reset),    1);
        power_on_reset = 1'b0;
        cyc = 0;

        // ---- default free run, N=2 ----
        for (int c = 1; c <= 20; c++) begin
            next();
            check($sformatf("t1 en@%0d", cyc),  32'(clk_en),       32'(cyc % 2 == 0));
            check($sformatf("t1 out@%0d", cyc), 32'(clk_out),      32'((cyc / 2) % 2 == 1));
            check($sformatf("t1 sr@%0d", cyc),  32'(system_reset), 32'(cyc < 16));
        end

        // ---- divisor 4 written in cycle 5, applies at the boundary ----
        do_reset();
        exp_out = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            next();
            exp_en = 1'b0;
            for (int i = 0; i < 8; i++) if (ticks2[i] == cyc) exp_en = 1'b1;
            if (exp_en) exp_out = ~exp_out;
            check($sformatf("t2 en@%0d", cyc),  32'(clk_en),          32'(exp_en));
            check($sformatf("t2 out@%0d", cyc), 32'(clk_out),         32'(exp_out));
            check($sformatf("t2 cur@%0d", cyc), 32'(div_bus.div_cur), (cyc < 6) ? 1 : 4);
            check($sformatf("t2 sr@%0d", cyc),  32'(system_reset),    32'(cyc < 31));
            if (cyc == 4) begin
                div_bus.div_wr  = 1'b1;
                div_bus.div_val = 8'd4;
            end else begin
                div_bus.div_wr  = 1'b0;
            end
        end

        // ---- divisor 0 written on a boundary edge, then 255 ----
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            next();
            if (cyc >= 2) begin
                check($sformatf("t3 en@%0d", cyc),  32'(clk_en),  32'(cyc == 2 || cyc >= 4));
                check($sformatf("t3 out@%0d", cyc), 32'(clk_out), (cyc < 4) ? 1 : 32'(cyc % 2 == 1));
            end
            check($sformatf("t3 cur@%0d", cyc), 32'(div_bus.div_cur), (cyc < 4) ? 1 : 0);
            check($sformatf("t3 sr@%0d", cyc),  32'(system_reset),    32'(cyc < 10));
            if (cyc == 1) begin
                div_bus.div_wr  = 1'b1;
                div_bus.div_val = 8'd0;
            end else if (cyc == 12) begin
                div_bus.div_wr  = 1'b1;
                div_bus.div_val = 8'd255;
            end else begin
                div_bus.div_wr  = 1'b0;
            end
        end
        next();
        div_bus.div_wr = 1'b0;
        check("t3 cur@13", 32'(div_bus.div_cur), 0);
        check("t3 en@13",  32'(clk_en),          1);
        next();
        check("t3 cur@14", 32'(div_bus.div_cur), 255);
        check("t3 en@14",  32'(clk_en),          1);
        en_cnt = 0;
        run_to(269);
        check("t3 no en 15..269", 32'(en_cnt), 0);
        next();
        check("t3 en@270", 32'(clk_en), 1);
        next();
        check("t3 en@271", 32'(clk_en), 0);

        // ---- button glitch then long press, N=2 ----
        do_reset();
        run_to(20);
        btn_n  = 1'b0;
        ev_cnt = 0;
        pr_cnt = 0;
        sr_low = 0;
        run_to(30);
        btn_n  = 1'b1;
        run_to(50);
        check("t4 glitch pressed", 32'(pr_cnt), 0);
        check("t4 glitch event",   32'(ev_cnt), 0);
        check("t4 glitch sr low",  32'(sr_low), 30);
        run_to(60);
        btn_n  = 1'b0;
        ev_cnt = 0;
        run_to(77);
        check("t4 pressed@77", 32'(btn_pressed), 0);
        run_to(78);
        check("t4 pressed@78", 32'(btn_pressed),  1);
        check("t4 event@78",   32'(btn_event),    1);
        check("t4 sr@78",      32'(system_reset), 0);
        run_to(79);
        check("t4 event@79",   32'(btn_event),    0);
        check("t4 sr@79",      32'(system_reset), 1);
        run_to(100);
        btn_n  = 1'b1;
        sr_low = 0;
        run_to(117);
        check("t4 pressed@117", 32'(btn_pressed), 1);
        run_to(118);
        check("t4 pressed@118", 32'(btn_pressed), 0);
        run_to(133);
        check("t4 sr@133", 32'(system_reset), 1);
        run_to(134);
        check("t4 sr@134", 32'(system_reset), 0);
        check("t4 sr low count", 32'(sr_low), 1);
        check("t4 event count",  32'(ev_cnt), 1);

        // ---- release, re-press after 3 ticks, N=10 ----
        do_reset();
        next();
        div_bus.div_wr  = 1'b1;
        div_bus.div_val = 8'd9;
        next();
        div_bus.div_wr  = 1'b0;
        btn_n = 1'b0;
        wait_pressed(1'b1, 40, "t5 press1");
        repeat (10) next();
        btn_n = 1'b1;
        wait_pressed(1'b0, 40, "t5 release1");
        sr_low = 0;
        en_cnt = 0;
        ev_cnt = 0;
        wait_ticks(3, 60, "t5 three ticks");
        check("t5 sr at repress", 32'(system_reset), 1);
        btn_n = 1'b0;
        wait_pressed(1'b1, 40, "t5 press2");
        repeat (10) next();
        check("t5 press event", 32'(ev_cnt), 1);
        btn_n = 1'b1;
        wait_pressed(1'b0, 40, "t5 release2");
        check("t5 sr held",          32'(sr_low), 0);
        check("t5 no release event", 32'(ev_cnt), 1);
        sr_low = 0;
        en_cnt = 0;
        wait_ticks(7, 100, "t5 seven ticks");
        check("t5 sr@tick7", 32'(system_reset), 1);
        wait_ticks(8, 20, "t5 eight ticks");
        check("t5 sr@tick8",    32'(system_reset), 0);
        check("t5 sr low once", 32'(sr_low),       1);

        // ---- power-on reset mid-countdown with a pending write ----
        do_reset();
        run_to(10);
        div_bus.div_wr  = 1'b1;
        div_bus.div_val = 8'd50;
        next();
        div_bus.div_wr  = 1'b0;
        check("t6 cur@11", 32'(div_bus.div_cur), 1);
        check("t6 out@11", 32'(clk_out),         1);
        power_on_reset = 1'b1;
        next();
        check("t6 rst clk_en",  32'(clk_en),          0);
        check("t6 rst clk_out", 32'(clk_out),         0);
        check("t6 rst div_cur", 32'(div_bus.div_cur), 1);
        check("t6 rst sr",      32'(system_reset),    1);
        power_on_reset = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 16; c++) begin
            next();
            check($sformatf("t6 en@%0d", cyc),  32'(clk_en),          32'(cyc % 2 == 0));
            check($sformatf("t6 cur@%0d", cyc), 32'(div_bus.div_cur), 1);
            check($sformatf("t6 sr@%0d", cyc),  32'(system_reset),    32'(cyc < 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
